// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode encoding and pattern helpers for led_pattern_engine
package led_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_BLINK  = 3'd1,
        MODE_CHASE  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_COUNT  = 3'd4,
        MODE_AUTO   = 3'd5
    } mode_t;

    // Reserved encodings (6, 7) behave exactly like OFF.
    function automatic mode_t decode_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            3'd1:    return MODE_BLINK;
            3'd2:    return MODE_CHASE;
            3'd3:    return MODE_BOUNCE;
            3'd4:    return MODE_COUNT;
            3'd5:    return MODE_AUTO;
            default: return MODE_OFF;
        endcase
    endfunction

    // Every init pattern is either all-zero or a single lit bit0, so the
    // width-independent part of the init value is just its LSB.
    function automatic logic init_lsb(input mode_t m);
        return (m == MODE_CHASE) || (m == MODE_BOUNCE);
    endfunction

    // AUTO rotation order: BLINK -> CHASE -> BOUNCE -> COUNT -> BLINK.
    function automatic mode_t next_auto(input mode_t m);
        case (m)
            MODE_BLINK:  return MODE_CHASE;
            MODE_CHASE:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_COUNT;
            default:     return MODE_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - step prescaler, counts 0..DIV-1 and flags the last count
module led_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic step
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Prescaler: clear wins over hold so a reload always restarts the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign step = !rst && !hold && (cnt == LAST);

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - multi-mode LED pattern generator (optional PWM stage: LED_PWM_EN)
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int STEP_HZ    = 2,
    parameter int NUM_LEDS   = 4,
    parameter int AUTO_STEPS = 8,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic                mode_load_i,
    input  logic                pause_i,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] brightness_i,
`endif
    output logic [NUM_LEDS-1:0] led_o,
    output logic                step_o,
    output logic [MODE_W-1:0]   mode_o
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int AW  = $clog2(AUTO_STEPS + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEPS - 1);

    if (DIV < 2 || NUM_LEDS < 2 || AUTO_STEPS < 1 || PWM_BITS < 1) begin : g_bad_cfg
        $error("led_pattern_engine: invalid parameter set");
    end

    function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_t m);
        return {{(NUM_LEDS-1){1'b0}}, init_lsb(m)};
    endfunction

    mode_t               mode_q, mode_d;
    mode_t               sub_q, sub_d;
    mode_t               active;
    mode_t               load_mode;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    logic                dir_up_q, dir_up_d;
    logic [AW-1:0]       auto_cnt_q, auto_cnt_d;
    logic                step;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_load_i),
        .hold (pause_i),
        .step (step)
    );

    assign load_mode = decode_mode(mode_i);
    assign active    = (mode_q == MODE_AUTO) ? sub_q : mode_q;
    assign step_o    = step;
    assign mode_o    = active;

    // Mode, pattern, bounce direction and AUTO sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_OFF;
            sub_q      <= MODE_BLINK;
            pattern_q  <= '0;
            dir_up_q   <= 1'b1;
            auto_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            sub_q      <= sub_d;
            pattern_q  <= pattern_d;
            dir_up_q   <= dir_up_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    // Next state: a load restarts everything and swallows a coincident step.
    always_comb begin
        mode_d     = mode_q;
        sub_d      = sub_q;
        pattern_d  = pattern_q;
        dir_up_d   = dir_up_q;
        auto_cnt_d = auto_cnt_q;
        if (mode_load_i) begin
            mode_d     = load_mode;
            sub_d      = MODE_BLINK;
            pattern_d  = init_pattern((load_mode == MODE_AUTO) ? MODE_BLINK : load_mode);
            dir_up_d   = 1'b1;
            auto_cnt_d = '0;
        end else if (step) begin
            if (mode_q == MODE_AUTO && auto_cnt_q == AUTO_LAST) begin
                // Sub-mode switch: the new sub-mode starts from its init value.
                auto_cnt_d = '0;
                sub_d      = next_auto(sub_q);
                pattern_d  = init_pattern(next_auto(sub_q));
                dir_up_d   = 1'b1;
            end else begin
                if (mode_q == MODE_AUTO) begin
                    auto_cnt_d = auto_cnt_q + 1'b1;
                end
                case (active)
                    MODE_BLINK:  pattern_d = ~pattern_q;
                    MODE_CHASE:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                    MODE_BOUNCE: begin
                        // Reverse on arrival at an end so the end LED is not repeated.
                        if (dir_up_q) begin
                            pattern_d = pattern_q << 1;
                            if (pattern_q[NUM_LEDS-2]) dir_up_d = 1'b0;
                        end else begin
                            pattern_d = pattern_q >> 1;
                            if (pattern_q[1]) dir_up_d = 1'b1;
                        end
                    end
                    MODE_COUNT:  pattern_d = pattern_q + 1'b1;
                    default:     pattern_d = '0;
                endcase
            end
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_q;
    logic [NUM_LEDS-1:0] led_q;

    // Free-running PWM counter and gated output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
            led_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
            led_q <= pattern_q & {NUM_LEDS{pwm_q < brightness_i}};
        end
    end

    assign led_o = led_q;
`else
    assign led_o = pattern_q;
`endif

endmodule
